// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
// Build option: define DMEM_ARB_RR_EN for round-robin tie-breaking,
// otherwise requester 0 always wins ties.
package dmem_arb_pkg;

    localparam int unsigned NUM_REQ    = 2;
    localparam int unsigned DEF_ADDR_W = 16;
    localparam int unsigned DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_e;

endpackage

// File: rtl/dmem_arb_pick.sv
// Winner selection for the data-memory arbiter: one-hot winner from the
// request vector and the index of the requester served last.
// Build option: DMEM_ARB_RR_EN selects round-robin; default is fixed
// priority with requester 0 first, and the last-winner input is ignored.
module dmem_arb_pick
    import dmem_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic               last,
    output logic [NUM_REQ-1:0] win
);

    // Combinational arbitration; zero or one bit of win is ever set.
    always_comb begin
        win = '0;
`ifdef DMEM_ARB_RR_EN
        if (req == 2'b11) begin
            // Tie: the requester not served last goes first.
            win = last ? 2'b01 : 2'b10;
        end else begin
            win = req;
        end
`else
        if (req[0]) begin
            win = 2'b01;
        end else if (req[1]) begin
            win = 2'b10;
        end
`endif
    end

`ifndef DMEM_ARB_RR_EN
    logic unused_last;
    assign unused_last = last;
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter in front of a single-port data memory.
// One transaction in flight: stores take IDLE->ACCESS (2 cycles), loads
// take IDLE->ACCESS->RESP (3 cycles). rdata is registered and held.
// Build option: DMEM_ARB_RR_EN enables round-robin tie-breaking with a
// last-winner register; without it requester 0 wins every tie.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        we,
    input  logic [NUM_REQ*ADDR_W-1:0] addr,
    input  logic [NUM_REQ*DATA_W-1:0] wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rvalid,
    output logic [DATA_W-1:0]         rdata,
    output logic                      busy,
    output logic                      mem_wEn,
    output logic [ADDR_W-1:0]         mem_address,
    output logic [DATA_W-1:0]         mem_write_data,
    input  logic [DATA_W-1:0]         mem_read_data
);

    arb_state_e          state_q, state_d;
    logic [NUM_REQ-1:0]  winner_q;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rdata_q;

    logic [NUM_REQ-1:0]  win;
    logic                last_w;
    logic                capture;
    logic                sel_idx;

    assign capture = (state_q == IDLE) && (req != '0);
    assign sel_idx = win[1];

`ifdef DMEM_ARB_RR_EN
    logic last_q;

    // Remember who was picked so the other requester wins the next tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else if (capture) begin
            last_q <= sel_idx;
        end
    end

    assign last_w = last_q;
`else
    assign last_w = 1'b1;
`endif

    dmem_arb_pick u_pick (
        .req  (req),
        .last (last_w),
        .win  (win)
    );

    // State register plus latched transaction and captured load data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            winner_q <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                winner_q <= win;
                we_q     <= sel_idx ? we[1] : we[0];
                addr_q   <= sel_idx ? addr[ADDR_W +: ADDR_W] : addr[0 +: ADDR_W];
                wdata_q  <= sel_idx ? wdata[DATA_W +: DATA_W] : wdata[0 +: DATA_W];
            end
            if (state_q == ACCESS && !we_q) begin
                rdata_q <= mem_read_data;
            end
        end
    end

    // Next-state and per-state outputs.
    always_comb begin
        state_d = state_q;
        gnt     = '0;
        rvalid  = '0;
        mem_wEn = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req != '0) begin
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                gnt = winner_q;
                // Reset masks the strobe so an aborted store never commits.
                mem_wEn = we_q & ~rst;
                state_d = we_q ? IDLE : RESP;
            end
            RESP: begin
                rvalid  = winner_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy           = (state_q != IDLE);
    assign rdata          = rdata_q;
    assign mem_address    = addr_q;
    assign mem_write_data = wdata_q;

endmodule
